// File: rtl/pe_link_arbiter_if.sv
// Link-side bundle for pe_link_arbiter: the two flit sources, router handshake and output register.
// The slave modport is the arbiter; the master modport is the PE/router side that drives it.
package my_pkg;
   parameter int PACKET_LENGTH = 16;
endpackage

interface pe_link_arbiter_if #(parameter int PKT_W = my_pkg::PACKET_LENGTH);
   logic             req_vld;
   logic [PKT_W-1:0] req_pkt;
   logic             req_pop;
   logic             rsp_vld;
   logic [PKT_W-1:0] rsp_pkt;
   logic             rsp_pop;
   logic             hold;
   logic             read;
   logic             vld_out;
   logic [PKT_W-1:0] dout;
   logic             last_src;

   modport master (
      output req_vld, req_pkt, rsp_vld, rsp_pkt, hold, read,
      input  req_pop, rsp_pop, vld_out, dout, last_src
   );

   modport slave (
      input  req_vld, req_pkt, rsp_vld, rsp_pkt, hold, read,
      output req_pop, rsp_pop, vld_out, dout, last_src
   );
endinterface

// File: rtl/pe_link_arbiter.sv
// Response-priority arbiter for the PE router output link, with a bounded response burst
// so a waiting request always gets a slot, and a registered output stage.
//
// state     | meaning
// RESP_FAV  | responses win; burst_cnt counts rsp grants taken while a request waits
// REQ_FORCE | burst limit reached; the waiting request wins the next grant
module pe_link_arbiter #(
   parameter int PKT_W          = my_pkg::PACKET_LENGTH,
   parameter int MAX_RESP_BURST = 4,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   pe_link_arbiter_if.slave lnk,
   output logic             busy,
   output logic [CNT_W-1:0] req_grants,
   output logic [CNT_W-1:0] rsp_grants
);

   typedef enum logic {
      RESP_FAV  = 1'b0,
      REQ_FORCE = 1'b1
   } state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_RESP_BURST);

   state_t     state;
   logic [3:0] burst_cnt;
   logic       can_load;
   logic       grant_req;
   logic       grant_rsp;

   assign can_load = !lnk.hold && (!lnk.vld_out || lnk.read);

   always_comb begin
      grant_req = 1'b0;
      grant_rsp = 1'b0;
      if (can_load) begin
         if (state == RESP_FAV) begin
            grant_rsp = lnk.rsp_vld;
            grant_req = !lnk.rsp_vld && lnk.req_vld;
         end else begin
            grant_req = lnk.req_vld;
            grant_rsp = !lnk.req_vld && lnk.rsp_vld;
         end
      end
   end

   assign lnk.req_pop = grant_req;
   assign lnk.rsp_pop = grant_rsp;
   assign busy        = lnk.vld_out | lnk.req_vld | lnk.rsp_vld;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state        <= RESP_FAV;
         burst_cnt    <= '0;
         lnk.vld_out  <= 1'b0;
         lnk.dout     <= '0;
         lnk.last_src <= 1'b0;
         req_grants   <= '0;
         rsp_grants   <= '0;
      end else begin
         if (can_load) begin
            case (state)
               RESP_FAV: begin
                  if (grant_req) begin
                     burst_cnt <= '0;
                  end else if (grant_rsp && lnk.req_vld) begin
                     burst_cnt <= burst_cnt + 4'd1;
                     if (burst_cnt + 4'd1 == MAX_B)
                        state <= REQ_FORCE;
                  end
               end
               REQ_FORCE: begin
                  // A rsp grant here means the request withdrew; either way the burst is over.
                  if (grant_req || grant_rsp) begin
                     burst_cnt <= '0;
                     state     <= RESP_FAV;
                  end
               end
               default: state <= RESP_FAV;
            endcase
         end

         if (grant_req || grant_rsp) begin
            lnk.vld_out  <= 1'b1;
            lnk.dout     <= grant_rsp ? lnk.rsp_pkt : lnk.req_pkt;
            lnk.last_src <= grant_rsp;
         end else if (lnk.read) begin
            lnk.vld_out <= 1'b0;
         end

         if (grant_req && req_grants != {CNT_W{1'b1}})
            req_grants <= req_grants + 1'b1;
         if (grant_rsp && rsp_grants != {CNT_W{1'b1}})
            rsp_grants <= rsp_grants + 1'b1;
      end
   end

endmodule

// File: tb/tb_pe_link_arbiter.sv
// Directed bench for pe_link_arbiter: a default instance plus a CNT_W=4, MAX_RESP_BURST=1 instance
// for counter saturation and strict alternation.
module tb_pe_link_arbiter;

   logic clk;
   logic arst_n;
   int   n_vec;
   int   n_err;

   pe_link_arbiter_if #(.PKT_W(16)) m ();
   pe_link_arbiter_if #(.PKT_W(16)) s ();

   logic        m_busy;
   logic [15:0] m_req_grants;
   logic [15:0] m_rsp_grants;
   logic        s_busy;
   logic [3:0]  s_req_grants;
   logic [3:0]  s_rsp_grants;

   pe_link_arbiter #(.PKT_W(16), .MAX_RESP_BURST(4), .CNT_W(16)) u_main (
      .clk        (clk),
      .arst_n     (arst_n),
      .lnk        (m.slave),
      .busy       (m_busy),
      .req_grants (m_req_grants),
      .rsp_grants (m_rsp_grants)
   );

   pe_link_arbiter #(.PKT_W(16), .MAX_RESP_BURST(1), .CNT_W(4)) u_sat (
      .clk        (clk),
      .arst_n     (arst_n),
      .lnk        (s.slave),
      .busy       (s_busy),
      .req_grants (s_req_grants),
      .rsp_grants (s_rsp_grants)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] flits [3];
   logic        exp_rsp;

   initial begin
      n_vec = 0;
      n_err = 0;
      flits[0] = 16'h0011;
      flits[1] = 16'h0022;
      flits[2] = 16'h0033;
      arst_n = 1'b0;
      m.req_vld = 1'b0; m.req_pkt = '0; m.rsp_vld = 1'b0; m.rsp_pkt = '0; m.hold = 1'b0; m.read = 1'b0;
      s.req_vld = 1'b0; s.req_pkt = '0; s.rsp_vld = 1'b0; s.rsp_pkt = '0; s.hold = 1'b0; s.read = 1'b0;
      tick;
      tick;
      arst_n = 1'b1;
      #1;
      check("rst_vld_out", m.vld_out, 0);
      check("rst_busy", m_busy, 0);

      // fill the OR with 0xABCD, then reset mid-cycle
      m.req_vld = 1'b1; m.req_pkt = 16'hABCD; m.read = 1'b1;
      #1;
      check("rst_fill_pop", m.req_pop, 1);
      tick;
      m.req_vld = 1'b0;
      check("rst_full_dout", m.dout, 16'hABCD);
      #2 arst_n = 1'b0;
      #1;
      check("rst_async_vld", m.vld_out, 0);
      check("rst_async_dout", m.dout, 0);
      tick;
      arst_n = 1'b1;
      #1;
      check("rst_req_grants", m_req_grants, 0);
      check("rst_rsp_grants", m_rsp_grants, 0);
      check("rst_last_src", m.last_src, 0);

      // single source, three flits back to back
      m.req_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m.req_pkt = flits[i];
         #1;
         check("single_busy", m_busy, 1);
         check("single_pop", m.req_pop, 1);
         tick;
         check("single_dout", m.dout, flits[i]);
         check("single_src", m.last_src, 0);
      end
      m.req_vld = 1'b0;
      check("single_grants", m_req_grants, 3);
      tick;
      check("single_drain", m.vld_out, 0);

      // both sources rise together: rsp x4, req, repeating
      m.req_vld = 1'b1; m.req_pkt = 16'h1000;
      m.rsp_vld = 1'b1; m.rsp_pkt = 16'h2000;
      for (int g = 0; g < 20; g++) begin
         exp_rsp = (g % 5) != 4;
         #1;
         check("starve_rsp_pop", m.rsp_pop, exp_rsp);
         check("starve_req_pop", m.req_pop, !exp_rsp);
         tick;
         check("starve_src", m.last_src, exp_rsp);
      end
      check("starve_rsp_grants", m_rsp_grants, 16);
      check("starve_req_grants", m_req_grants, 7);

      // backpressure: OR holds 0x1000 from the last req grant
      m.read = 1'b0; m.rsp_pkt = 16'h2001;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_req_pop", m.req_pop, 0);
         check("bp_rsp_pop", m.rsp_pop, 0);
         tick;
         check("bp_dout", m.dout, 16'h1000);
         check("bp_vld", m.vld_out, 1);
      end
      m.read = 1'b1;
      #1;
      check("bp_release_pop", m.rsp_pop, 1);
      tick;
      check("bp_release_dout", m.dout, 16'h2001);
      check("bp_release_src", m.last_src, 1);
      check("bp_release_vld", m.vld_out, 1);

      // hold with OR full: flit still drains, nothing granted, burst_cnt frozen at 1
      m.hold = 1'b1;
      #1;
      check("hold_rsp_pop", m.rsp_pop, 0);
      check("hold_req_pop", m.req_pop, 0);
      tick;
      check("hold_drain", m.vld_out, 0);
      tick;
      check("hold_rsp_grants", m_rsp_grants, 17);
      m.hold = 1'b0;
      for (int g = 0; g < 4; g++) begin
         exp_rsp = (g != 3);
         #1;
         check("hold_resume_rsp", m.rsp_pop, exp_rsp);
         check("hold_resume_req", m.req_pop, !exp_rsp);
         tick;
      end
      check("hold_req_grants", m_req_grants, 8);

      // reach REQ_FORCE, then withdraw the request
      for (int g = 0; g < 4; g++) begin
         #1;
         check("wd_pre_rsp", m.rsp_pop, 1);
         tick;
      end
      m.req_vld = 1'b0;
      #1;
      check("wd_rsp_pop", m.rsp_pop, 1);
      check("wd_req_pop", m.req_pop, 0);
      tick;
      m.req_vld = 1'b1;
      for (int g = 0; g < 5; g++) begin
         exp_rsp = (g != 4);
         #1;
         check("wd_after_rsp", m.rsp_pop, exp_rsp);
         check("wd_after_req", m.req_pop, !exp_rsp);
         tick;
      end
      m.req_vld = 1'b0; m.rsp_vld = 1'b0;

      // CNT_W=4 saturation on the second instance
      s.rsp_vld = 1'b1; s.rsp_pkt = 16'h0BEE; s.read = 1'b1;
      for (int g = 0; g < 20; g++) begin
         tick;
         if (g == 9) check("sat_mid", s_rsp_grants, 10);
      end
      check("sat_rsp_grants", s_rsp_grants, 15);
      check("sat_req_grants", s_req_grants, 0);

      // MAX_RESP_BURST=1: strict alternation starting with rsp
      s.req_vld = 1'b1; s.req_pkt = 16'h0CAF;
      for (int g = 0; g < 6; g++) begin
         exp_rsp = (g % 2) == 0;
         #1;
         check("alt_rsp_pop", s.rsp_pop, exp_rsp);
         check("alt_req_pop", s.req_pop, !exp_rsp);
         tick;
         check("alt_dout", s.dout, exp_rsp ? 32'h0BEE : 32'h0CAF);
      end
      check("alt_req_grants", s_req_grants, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
